int_to_float: RTL

Sequential 32-bit integer to IEEE-754 single-precision converter that produces operands for the floating-point ALU from integer sources. It is the encoding end of the float format the ALU's multiply, add/subtract, divide and compare units consume. Accepts one integer per transaction over a valid/ready handshake and normalises it iteratively. It rounds to nearest-even and returns the packed float with an inexact flag.

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp32_round_pack.sv | 50 +++++
 rtl/int_to_float.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision float constants and types.
// The integer converter and the floating-point ALU units both use this package.
package fp_pkg;

  // Field widths and bias of the packed IEEE-754 single-precision format
  localparam int FP_EXP_BIAS = 127;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MANT_W   = 23;
  localparam int INT_W       = 32;

  // Biased exponent of an integer whose leading one sits in bit INT_W-1
  localparam int FP_EXP_INT_TOP = FP_EXP_BIAS + INT_W - 1;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_e;

  // Packed float fields, most significant first
  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;

  // Legal coarse normalisation strides for int_to_float
  function automatic bit norm_step_legal(input int step);
    return (step == 1) || (step == 2) || (step == 4) || (step == 8) || (step == 16);
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Combinational round-to-nearest-even and pack stage.
// Takes a normalised magnitude (leading one already in the top bit and
// therefore implied) plus sign and biased exponent, and produces the packed
// float together with an inexact flag.
module fp32_round_pack
  import fp_pkg::*;
(
  input  logic                sign_i,
  input  logic [FP_EXP_W-1:0] exp_i,
  // normalised magnitude without its implied leading one
  input  logic [INT_W-2:0]    mag_i,
  output logic [INT_W-1:0]    data_o,
  output logic                inexact_o
);

  // Bits below the mantissa: one guard bit, the rest fold into sticky
  localparam int DROP_W = INT_W - 1 - FP_MANT_W;

  logic [FP_MANT_W-1:0] mant_trunc;
  logic                 guard_bit;
  logic                 sticky_bit;
  logic                 round_up;
  logic [FP_MANT_W:0]   mant_sum;
  fp32_t                result;

  // Round the truncated mantissa to nearest-even and renormalise on carry-out
  always_comb begin
    mant_trunc = mag_i[INT_W-2 -: FP_MANT_W];
    guard_bit  = mag_i[DROP_W-1];
    sticky_bit = |mag_i[DROP_W-2:0];
    // ties go to the even mantissa, anything above half rounds up
    round_up   = guard_bit & (sticky_bit | mant_trunc[0]);
    mant_sum   = {1'b0, mant_trunc} + {{FP_MANT_W{1'b0}}, round_up};

    result.sign = sign_i;
    if (mant_sum[FP_MANT_W]) begin
      // all-ones mantissa rolled over: value is the next power of two
      result.exp  = exp_i + FP_EXP_W'(1);
      result.mant = '0;
    end else begin
      result.exp  = exp_i;
      result.mant = mant_sum[FP_MANT_W-1:0];
    end

    inexact_o = guard_bit | sticky_bit;
  end

  assign data_o = result;

endmodule

// File: rtl/int_to_float.sv
// Sequential 32-bit integer to single-precision float converter.
// One operand per valid/ready transaction; the magnitude is normalised by an
// iterative left shifter (optionally in coarse strides of NORM_STEP bits),
// then rounded to nearest-even and packed. No operand buffering: a new
// operand is taken only in IDLE.
module int_to_float
  import fp_pkg::*;
#(
  parameter int NORM_STEP = 1
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_data,
  output logic             out_inexact
);

  // Stride is a shift amount on the magnitude; only powers of two up to 16 make sense
  if (!norm_step_legal(NORM_STEP)) begin : g_bad_norm_step
    $error("int_to_float: NORM_STEP must be 1, 2, 4, 8 or 16");
  end

  localparam logic [FP_EXP_W-1:0] EXP_INIT = FP_EXP_W'(FP_EXP_INT_TOP);
  localparam logic [FP_EXP_W-1:0] EXP_STEP = FP_EXP_W'(NORM_STEP);

  state_e              state_q, state_d;
  logic [INT_W-1:0]    mag_q, mag_d;
  logic [FP_EXP_W-1:0] exp_q, exp_d;
  logic                sign_q, sign_d;
  logic [INT_W-1:0]    out_data_q, out_data_d;
  logic                out_inexact_q, out_inexact_d;

  logic                accept;
  logic                in_is_zero;
  logic                coarse_zero;
  logic [INT_W-1:0]    rp_data;
  logic                rp_inexact;

  assign accept     = in_valid & in_ready;
  assign in_is_zero = (in_data == '0);

  // Coarse stride is allowed only when every bit it would push out is zero
  if (NORM_STEP > 1) begin : g_coarse
    assign coarse_zero = (mag_q[INT_W-1 -: NORM_STEP] == '0);
  end else begin : g_fine
    assign coarse_zero = 1'b0;
  end

  fp32_round_pack u_round_pack (
    .sign_i    (sign_q),
    .exp_i     (exp_q),
    .mag_i     (mag_q[INT_W-2:0]),
    .data_o    (rp_data),
    .inexact_o (rp_inexact)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_is_zero ? DONE : NORM;
        end
      end
      NORM: begin
        if (mag_q[INT_W-1]) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath next values: load on accept, shift while normalising, capture the rounded result
  always_comb begin
    mag_d         = mag_q;
    exp_d         = exp_q;
    sign_d        = sign_q;
    out_data_d    = out_data_q;
    out_inexact_d = out_inexact_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_is_zero) begin
            // zero has no leading one to find; emit +0 directly
            mag_d         = '0;
            exp_d         = '0;
            sign_d        = 1'b0;
            out_data_d    = '0;
            out_inexact_d = 1'b0;
          end else begin
            sign_d = in_signed & in_data[INT_W-1];
            // negating 0x80000000 yields 0x80000000, which is the correct magnitude
            mag_d  = sign_d ? (-in_data) : in_data;
            exp_d  = EXP_INIT;
          end
        end
      end
      NORM: begin
        if (!mag_q[INT_W-1]) begin
          if (coarse_zero) begin
            mag_d = mag_q << NORM_STEP;
            exp_d = exp_q - EXP_STEP;
          end else begin
            mag_d = mag_q << 1;
            exp_d = exp_q - FP_EXP_W'(1);
          end
        end
      end
      ROUND: begin
        out_data_d    = rp_data;
        out_inexact_d = rp_inexact;
      end
      default: begin
        // DONE holds the result stable
        out_data_d    = out_data_q;
        out_inexact_d = out_inexact_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q         <= '0;
      exp_q         <= '0;
      sign_q        <= 1'b0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      mag_q         <= mag_d;
      exp_q         <= exp_d;
      sign_q        <= sign_d;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule
